// File: rtl/game_ctrl.sv
// game_ctrl: row-scan sequencer and ball controller for the 8x8 pong display.
// The scan runs continuously; all game state moves only on frame boundaries.
module game_ctrl #(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int SIZE         = 2,
  parameter int ROW_CYCLES   = 1024,
  parameter int STEP_FRAMES  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIT_OF_WIDTH-1:0]   player_top,
  input  logic [BIT_OF_WIDTH-1:0]   player_down,
  input  logic [BIT_OF_WIDTH-1:0]   player_right,
  input  logic [BIT_OF_WIDTH-1:0]   player_left,
  output logic [BIT_OF_WIDTH-1:0]   count,
  output logic [2*BIT_OF_WIDTH-1:0] pos_ball,
  output logic                      row_latch,
  output logic                      frame_tick,
  output logic [3:0]                miss,
  output logic                      playing
);

  localparam int RCW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int FCW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int CW  = BIT_OF_WIDTH + 1;

  localparam logic [RCW-1:0]          ROW_LAST   = RCW'(ROW_CYCLES - 1);
  localparam logic [RCW-1:0]          ROW_PRE    = RCW'(ROW_CYCLES - 2);
  localparam logic [RCW-1:0]          LATCH_PRE  = RCW'(1);
  localparam logic [BIT_OF_WIDTH-1:0] ROW_MAX    = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [BIT_OF_WIDTH-1:0] COORD_LO   = BIT_OF_WIDTH'(1);
  localparam logic [BIT_OF_WIDTH-1:0] COORD_HI   = BIT_OF_WIDTH'(WIDTH - 2);
  localparam logic [BIT_OF_WIDTH-1:0] CENTER     = BIT_OF_WIDTH'(WIDTH / 2 - 1);
  localparam logic [FCW-1:0]          FRAME_LAST = FCW'(STEP_FRAMES - 1);
  localparam logic [CW-1:0]           SPAN       = CW'(SIZE - 1);
  localparam logic [CW-1:0]           FAR_LO     = CW'(WIDTH - SIZE);
  localparam logic [CW-1:0]           FAR_HI     = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY} state_t;

  state_t                  state;
  logic [RCW-1:0]          row_cnt;
  logic [FCW-1:0]          frame_cnt;
  logic [BIT_OF_WIDTH-1:0] ball_x;
  logic [BIT_OF_WIDTH-1:0] ball_y;
  logic                    dir_x;
  logic                    dir_y;
  logic                    serve_x;
  logic                    serve_y;

  logic [CW-1:0]           bx_w;
  logic [CW-1:0]           by_w;
  logic                    cov_left;
  logic                    cov_right;
  logic                    cov_down;
  logic                    cov_top;
  logic [BIT_OF_WIDTH-1:0] next_x;
  logic [BIT_OF_WIDTH-1:0] next_y;
  logic                    next_dx;
  logic                    next_dy;
  logic                    miss_l;
  logic                    miss_r;
  logic                    miss_t;
  logic                    miss_d;
  logic [3:0]              step_miss;

  assign pos_ball = {ball_x, ball_y};

  // Paddle coverage is checked with one spare bit so pos+SIZE never wraps.
  assign bx_w      = {1'b0, ball_x};
  assign by_w      = {1'b0, ball_y};
  assign cov_left  = (by_w >= {1'b0, player_left}) && (by_w <= {1'b0, player_left} + SPAN);
  assign cov_right = (by_w + {1'b0, player_right} >= FAR_LO) && (by_w + {1'b0, player_right} <= FAR_HI);
  assign cov_down  = (bx_w >= {1'b0, player_down}) && (bx_w <= {1'b0, player_down} + SPAN);
  assign cov_top   = (bx_w + {1'b0, player_top} >= FAR_LO) && (bx_w + {1'b0, player_top} <= FAR_HI);

  // Row-scan counters; row_latch and frame_tick are decoded one clock early so they come out registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt    <= '0;
      count      <= '0;
      row_latch  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      row_latch  <= (row_cnt == LATCH_PRE);
      frame_tick <= (row_cnt == ROW_PRE) && (count == ROW_MAX);
      if (row_cnt == ROW_LAST) begin
        row_cnt <= '0;
        count   <= (count == ROW_MAX) ? '0 : count + 1'b1;
      end else begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  // Candidate ball move for the next step, each axis resolved independently against its paddle.
  always_comb begin
    next_x  = ball_x;
    next_y  = ball_y;
    next_dx = dir_x;
    next_dy = dir_y;
    miss_l  = 1'b0;
    miss_r  = 1'b0;
    miss_t  = 1'b0;
    miss_d  = 1'b0;

    if (dir_x && (ball_x == COORD_HI)) begin
      if (cov_right) begin
        next_dx = 1'b0;
        next_x  = ball_x - 1'b1;
      end else begin
        miss_r = 1'b1;
      end
    end else if (!dir_x && (ball_x == COORD_LO)) begin
      if (cov_left) begin
        next_dx = 1'b1;
        next_x  = ball_x + 1'b1;
      end else begin
        miss_l = 1'b1;
      end
    end else begin
      next_x = dir_x ? ball_x + 1'b1 : ball_x - 1'b1;
    end

    if (dir_y && (ball_y == COORD_HI)) begin
      if (cov_down) begin
        next_dy = 1'b0;
        next_y  = ball_y - 1'b1;
      end else begin
        miss_d = 1'b1;
      end
    end else if (!dir_y && (ball_y == COORD_LO)) begin
      if (cov_top) begin
        next_dy = 1'b1;
        next_y  = ball_y + 1'b1;
      end else begin
        miss_t = 1'b1;
      end
    end else begin
      next_y = dir_y ? ball_y + 1'b1 : ball_y - 1'b1;
    end

    if (miss_l) begin
      step_miss = 4'b0001;
    end else if (miss_r) begin
      step_miss = 4'b0010;
    end else if (miss_t) begin
      step_miss = 4'b1000;
    end else if (miss_d) begin
      step_miss = 4'b0100;
    end else begin
      step_miss = 4'b0000;
    end
  end

  // Game state machine; everything here advances only on the edge closing a frame_tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      ball_x    <= CENTER;
      ball_y    <= CENTER;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      serve_x   <= 1'b1;
      serve_y   <= 1'b1;
      miss      <= 4'b0000;
      playing   <= 1'b0;
    end else begin
      miss <= 4'b0000;
      if (frame_tick) begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= SERVE;
              playing   <= 1'b1;
              frame_cnt <= '0;
              dir_x     <= serve_x;
              dir_y     <= serve_y;
            end
          end
          SERVE: begin
            if (frame_cnt == FRAME_LAST) begin
              state     <= PLAY;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          PLAY: begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              if (step_miss != 4'b0000) begin
                miss    <= step_miss;
                ball_x  <= CENTER;
                ball_y  <= CENTER;
                serve_x <= ~serve_x;
                serve_y <= ~serve_y;
                dir_x   <= ~serve_x;
                dir_y   <= ~serve_y;
                state   <= SERVE;
              end else begin
                ball_x <= next_x;
                ball_y <= next_y;
                dir_x  <= next_dx;
                dir_y  <= next_dy;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Sequencer for the 8x8 pong display and game. Generates the row-scan index consumed by the row renderer. Tells the column driver when the renderer's registered row data is valid. Owns the ball: position, direction, wall/paddle bounces, miss detection and re-serve. All state changes occur at frame boundaries, so every displayed frame is internally consistent.

## Interface
- `WIDTH`, 8: matrix edge length (rows = columns = WIDTH).
- `BIT_OF_WIDTH`, 3: bits per ball coordinate.
- `SIZE`, 2: paddle length in cells.
- `ROW_CYCLES`, 1024: clocks each row is held; minimum 4.
- `STEP_FRAMES`, 8: frames per ball step; also the SERVE hold length.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level; requests game start from IDLE.
- `player_top`, `player_down`, `player_right`, `player_left` in 3 each: paddle positions.
- `count` out 3: current scan row, to renderer.
- `pos_ball` out 6: {x[5:3], y[2:0]}, to renderer.
- `row_latch` out 1: one-cycle pulse; renderer output for `count` is valid, column driver latches it.
- `frame_tick` out 1: one-cycle pulse on the last clock of row WIDTH-1.
- `miss` out 4: one-cycle one-hot {top, down, right, left}; that side failed to return the ball.
- `playing` out 1: high in SERVE or PLAY.

## Operation
- **Scan (always running, independent of state):**
  - A row counter 0..ROW_CYCLES-1 advances `count` 0..7; `count` wraps 7->0.
  - `row_latch` is high at row-cycle offset 2, since the renderer is registered one clock behind `count`.
  - `frame_tick` is high at offset ROW_CYCLES-1 of row 7.
- **Ball domain:** x and y are each restricted to 1..6. Direction is dx, dy in {+1,-1}.
- **Paddle coverage (sampled at the step cycle):**
  - left covers y in [pL, pL+SIZE-1].
  - right covers y in [WIDTH-2-pR, WIDTH-1-pR].
  - down covers x in [pD, pD+SIZE-1].
  - top covers x in [WIDTH-2-pT, WIDTH-1-pT].
  - Compare in 4-bit arithmetic; no wrap.
- **States:** IDLE, SERVE, PLAY.
  - IDLE: ball held at (3,3); `playing`=0. On a `frame_tick` with `start`=1 -> SERVE.
  - SERVE: ball at (3,3); hold STEP_FRAMES frames, then -> PLAY. Direction = serve_dir.
  - PLAY: every STEP_FRAMES-th `frame_tick` is a step. Each axis is evaluated independently:
    - Not at an edge in the direction of motion: coordinate += d.
    - At an edge (x=6 with dx=+1 -> right; x=1 with dx=-1 -> left; y=6 with dy=+1 -> down; y=1 with dy=-1 -> top):
      - Paddle covers the other coordinate: negate d, coordinate -= old d (bounce).
      - Otherwise: miss.
    - On any miss: pulse that `miss` bit, ball -> (3,3), toggle serve_dir (both components), -> SERVE.
    - Double miss (corner): report one side only, priority left > right > top > down.
    - Double bounce: both axes reflect.
- **Serve direction:** serve_dir resets to (+1,+1).
- **`start`** is ignored outside IDLE. There is no return to IDLE except via reset.

## Timing
- **Reset values:**
  - `count`=0, `pos_ball`=6'b011_011, `row_latch`=0, `frame_tick`=0, `miss`=0, `playing`=0.
  - State IDLE; frame/step counters 0; dx=dy=+1.
- **Frame-boundary updates:** `pos_ball`, state, `playing` and `miss` update only on the clock edge ending a `frame_tick` cycle. This is the same edge on which `count` wraps 7->0. `miss` is high for the following single cycle.
- **Row 0 after reset:** the first `row_latch` occurs 2 clocks after `rst` deasserts.
- **Frame period:** 8*ROW_CYCLES clocks. Step period: STEP_FRAMES frames.
- **Reset mid-frame or mid-game:** all state returns to reset values immediately; no `miss` or `frame_tick` is emitted.
- **Paddle inputs:** may change at any time; only the value at the step edge matters.

## Test plan
- **Reset/scan (ROW_CYCLES=4):**
  - `count` sequence 0,0,0,0,1… across clocks.
  - `row_latch` at offsets 2, 6, 10…
  - `frame_tick` at clock 31; `pos_ball`=6'h1B.
- **Start:** `start`=1 in IDLE.
  - `playing` rises at the first `frame_tick`.
  - After STEP_FRAMES frames in SERVE, the first step moves the ball (3,3) -> (4,4).
- **Left bounce:** ball (1,3), dx=-1, dy=+1, `player_left`=3 -> next (2,4), dx=+1.
- **Left miss:** ball (1,3), dx=-1, dy=+1, `player_left`=5.
  - `miss`=4'b0001 for one cycle; ball -> (3,3); state SERVE.
  - Next serve direction (-1,-1).
- **Corner, double miss:** ball (6,6), dx=dy=+1, no coverage -> `miss`=4'b0010 (right) only.
- **Corner bounce, then reset:** ball (6,6), `player_right`=0, `player_down`=5.
  - Result (5,5), dx=dy=-1.
  - Assert `rst` mid-row: all outputs return to reset values the same cycle.
